// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one divide-by-1e6 unit among NUM_REQ requesters.
// One operation in flight: IDLE grants, WAIT counts divider latency, RESP returns.
module divider_arbiter #(
    parameter int Data_Depth = 8,
    parameter int NUM_REQ    = 4,
    parameter int DIV_LAT    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*4*Data_Depth-1:0]  req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [4*Data_Depth-1:0]          div_operand,
    input  logic [4*Data_Depth-1:0]          div_result,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [4*Data_Depth-1:0]          rsp_data,
    input  logic                             rsp_ready,
    output logic                             busy
);

    localparam int W  = 4 * Data_Depth;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

    if (DIV_LAT < 1) begin : g_lat_chk
        $error("divider_arbiter: DIV_LAT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    op_q, op_d;
    logic [W-1:0]    rdata_q, rdata_d;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     cand;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    // Next-state logic: grant, latency countdown, response hold
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rdata_d   = rdata_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    op_d    = req_data[int'(grant_idx)*W +: W];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    cnt_d   = CW'(DIV_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rdata_d = div_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
            id_q    <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

    // Response id is one-hot only while a result is being offered
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[id_q] = 1'b1;
        end
    end

    assign div_operand = op_q;
    assign rsp_data    = rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: scoreboard of expected quotients and ids,
// plus a DIV_LAT=3 instance for latency and junk-result checks.
module tb_divider_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   div_operand, div_result, rsp_data;
    logic           rsp_ready, busy;

    logic [N-1:0]   req_valid3, req_ready3, rsp_valid3;
    logic [N*W-1:0] req_data3;
    logic [W-1:0]   div_operand3, div_result3, rsp_data3;
    logic           rsp_ready3, busy3, junk3;
    logic [W-1:0]   p1, p2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    divider_arbiter #(.Data_Depth(8), .NUM_REQ(N), .DIV_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .div_operand(div_operand), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    divider_arbiter #(.Data_Depth(8), .NUM_REQ(N), .DIV_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
        .div_operand(div_operand3), .div_result(div_result3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready3),
        .busy(busy3)
    );

    function automatic logic [W-1:0] div_model(input logic [W-1:0] x);
        return x / 32'd1_000_000;
    endfunction

    // Divider models: combinational for latency 1, two-stage pipe for latency 3
    assign div_result = div_model(div_operand);
    always @(posedge clk) begin
        p1 <= div_operand3;
        p2 <= p1;
    end
    assign div_result3 = junk3 ? 32'hDEAD_BEEF : div_model(p2);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   grants[$];
    int   gcyc[$];
    int   hs_cyc;
    bit   rsp_seen;

    // Monitor for the latency-1 instance: push on handshake, pop on response
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rsp_seen <= 1'b0;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                check("rdy_onehot", $countones(req_ready), 1);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        grants.push_back(i);
                        gcyc.push_back(cyc);
                        sb_q.push_back(exp_t'{id: req_ready,
                            data: div_model(req_data[i*W +: W])});
                    end
                end
                hs_cyc <= cyc;
            end
            if (rsp_valid != '0 && !rsp_seen) begin
                check("latency", cyc, hs_cyc + 2);
                rsp_seen <= 1'b1;
            end
            if (rsp_valid != '0 && rsp_ready) begin
                rsp_seen <= 1'b0;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", rsp_valid, e.id);
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        rsp_ready  = 1'b0;
        rsp_ready3 = 1'b0;
        junk3      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        grants.delete();
        gcyc.delete();
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grants.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (grants.size() < n) check("grant_timeout", grants.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic op(input int i, input logic [W-1:0] d,
                      input logic [W-1:0] exp);
        int k = 0;
        req_data[i*W +: W] = d;
        req_valid          = '0;
        req_valid[i]       = 1'b1;
        tick();
        req_valid = '0;
        while (rsp_valid == '0 && k < 10) begin
            tick();
            k++;
        end
        check("t3_id", rsp_valid, N'(1) << i);
        check("t3_data", rsp_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_data  = '0;
        req_data3 = '0;
        do_reset();

        check("rst_ready", req_ready, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_op", div_operand, 0);
        check("rst_busy", busy, 0);

        // single request, response held under backpressure
        tick();
        req_data[2*W +: W] = 5_000_000;
        req_valid          = 4'b0100;
        #1 check("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("t1_busy", busy, 1);
        check("t1_norsp", rsp_valid, 0);
        tick();
        check("t1_rspv", rsp_valid, 4'b0100);
        check("t1_data", rsp_data, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_v", rsp_valid, 4'b0100);
            check("t1_hold_d", rsp_data, 5);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_done", rsp_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_opkeep", div_operand, 5_000_000);

        // round-robin order and throughput
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = (i + 1) * 3_000_000;
        rsp_ready = 1'b1;
        req_valid = '1;
        wait_grants(4);
        req_valid = 4'b1001;
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t2_order", grants[i], i);
        for (int i = 1; i < 4 && i < gcyc.size(); i++)
            check("t2_gap", gcyc[i] - gcyc[i-1], 3);
        grants.delete();
        gcyc.delete();
        wait_grants(4);
        req_valid = '0;
        if (grants.size() >= 4) begin
            check("t2_o0", grants[0], 0);
            check("t2_o1", grants[1], 3);
            check("t2_o2", grants[2], 0);
            check("t2_o3", grants[3], 3);
        end
        wait_idle();
        tick();
        tick();

        // quotient boundaries
        do_reset();
        rsp_ready = 1'b1;
        op(1, 999_999, 0);
        op(2, 1_000_000, 1);
        op(3, 2_000_000_000, 2000);

        // latency-3 instance: operand stable, junk ignored
        do_reset();
        rsp_ready3              = 1'b1;
        req_data3[1*W +: W]     = 7_000_000;
        req_valid3              = 4'b0010;
        #1 check("t4_ready", req_ready3, 4'b0010);
        tick();
        req_valid3          = '0;
        req_data3[1*W +: W] = 32'h1234_5678;
        junk3               = 1'b1;
        check("t4_op1", div_operand3, 7_000_000);
        check("t4_nv1", rsp_valid3, 0);
        tick();
        check("t4_op2", div_operand3, 7_000_000);
        check("t4_nv2", rsp_valid3, 0);
        tick();
        junk3 = 1'b0;
        check("t4_op3", div_operand3, 7_000_000);
        check("t4_nv3", rsp_valid3, 0);
        tick();
        check("t4_rspv", rsp_valid3, 4'b0010);
        check("t4_data", rsp_data3, 7);
        tick();
        check("t4_idle", busy3, 0);

        // reset during WAIT aborts and restores priority
        do_reset();
        rsp_ready          = 1'b1;
        req_data[2*W +: W] = 4_000_000;
        req_valid          = 4'b0100;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        check("t5_rspv", rsp_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_op", div_operand, 0);
        check("t5_data", rsp_data, 0);
        check("t5_ready", req_ready, 0);
        rst = 1'b0;
        sb_q.delete();
        tick();
        check("t5_norsp", rsp_valid, 0);
        req_valid = '1;
        #1 check("t5_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_idle();

        // request raised and dropped while busy is never granted
        do_reset();
        req_data[0*W +: W] = 6_000_000;
        req_data[1*W +: W] = 9_000_000;
        req_valid          = 4'b0001;
        tick();
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            check("t6_noready", req_ready, 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_ready", req_ready, 0);
            tick();
        end
        check("t6_ngrants", grants.size(), 1);
        if (grants.size() > 0) check("t6_gid", grants[0], 0);
        check("t6_sb", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
